// File: rtl/multiphase_nonoverlap_gen.sv
// multiphase_nonoverlap_gen: N registered, mutually non-overlapping clock phases
// with run-time high/dead times, graceful stop and frame-done status.
module multiphase_nonoverlap_gen #(
    parameter int NUM_PHASES = 2,
    parameter int CNT_W      = 8
) (
    input  logic                          CLK_IN,
    input  logic                          RST,
    input  logic                          EN,
    input  logic [CNT_W-1:0]              HIGH_CYC,
    input  logic [CNT_W-1:0]              DEAD_CYC,
    output logic [NUM_PHASES-1:0]         PHI,
    output logic [$clog2(NUM_PHASES)-1:0] PHASE_IDX,
    output logic                          ACTIVE,
    output logic                          FRAME_DONE
);
    localparam int IDX_W = $clog2(NUM_PHASES);

    typedef enum logic [1:0] {IDLE, HIGH, DEAD} state_t;

    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        r_h;
    logic [CNT_W-1:0]        r_d;
    logic [IDX_W-1:0]        r_idx;
    logic [NUM_PHASES-1:0]   r_phi;
    logic                    r_active;
    logic                    r_frame_done;

    logic [CNT_W-1:0]        w_h_in;
    logic [CNT_W-1:0]        w_d_in;
    logic [CNT_W-1:0]        w_cnt_inc;
    logic [IDX_W-1:0]        w_idx_inc;
    logic                    w_last;
    logic                    w_start;

    assign w_h_in    = (HIGH_CYC == '0) ? CNT_W'(1) : HIGH_CYC;
    assign w_d_in    = (DEAD_CYC == '0) ? CNT_W'(1) : DEAD_CYC;
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_idx_inc = r_idx + 1'b1;
    assign w_last    = (r_idx == IDX_W'(NUM_PHASES - 1));
    // A frame starts from idle, or back-to-back once the final gap has fully elapsed
    assign w_start   = EN && ((r_state == IDLE) ||
                              (r_state == DEAD && r_cnt == r_d && w_last));

    always_ff @(posedge CLK_IN or posedge RST) begin
        if (RST) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_h          <= '0;
            r_d          <= '0;
            r_idx        <= '0;
            r_phi        <= '0;
            r_active     <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_start) begin
                r_state  <= HIGH;
                r_h      <= w_h_in;
                r_d      <= w_d_in;
                r_idx    <= '0;
                r_phi    <= {{(NUM_PHASES-1){1'b0}}, 1'b1};
                r_cnt    <= CNT_W'(1);
                r_active <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: r_active <= 1'b0;
                    HIGH: begin
                        if (r_cnt == r_h) begin
                            r_state      <= DEAD;
                            r_phi        <= '0;
                            r_cnt        <= CNT_W'(1);
                            r_frame_done <= w_last && (r_d == CNT_W'(1));
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    DEAD: begin
                        if (r_cnt == r_d) begin
                            if (!w_last) begin
                                r_state <= HIGH;
                                r_idx   <= w_idx_inc;
                                r_phi   <= {{(NUM_PHASES-1){1'b0}}, 1'b1} << w_idx_inc;
                                r_cnt   <= CNT_W'(1);
                            end else begin
                                r_state  <= IDLE;
                                r_active <= 1'b0;
                                r_cnt    <= '0;
                            end
                        end else begin
                            r_cnt        <= w_cnt_inc;
                            r_frame_done <= w_last && (w_cnt_inc == r_d);
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign PHI        = r_phi;
    assign PHASE_IDX  = r_idx;
    assign ACTIVE     = r_active;
    assign FRAME_DONE = r_frame_done;
endmodule
